sdram_responder: RTL and testbench

Synthesizable responder for the 16-bit SDR SDRAM command interface (MT48LC16M16 subset). It decodes the ACTIVE/READ/WRITE/PRECHARGE/AUTO_REFRESH/LOAD_MODE stream that our controllers emit and serves reads and writes from an on-chip block-RAM backing store. It replaces the external chip for in-FPGA controller self-test, and flags protocol violations for the verification bench.

---
 rtl/sdram_responder.sv | 206 ++++++++++++++++++++
 tb/tb_sdram_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// SDR SDRAM command responder: decodes the controller command stream, serves
// reads/writes from an on-chip backing store and flags protocol violations.
module sdram_responder #(
   parameter int MEM_AW = 14,
   parameter int TRCD   = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sd_cs,
   input  logic        sd_ras,
   input  logic        sd_cas,
   input  logic        sd_we,
   input  logic [12:0] sd_addr,
   input  logic [1:0]  sd_ba,
   input  logic [1:0]  sd_dqm,
   input  logic [15:0] sd_data_in,
   output logic [15:0] sd_data_out,
   output logic        sd_data_oe,
   output logic        mode_set,
   output logic [1:0]  cas_lat,
   output logic [15:0] refresh_cnt,
   output logic        err,
   output logic [2:0]  err_code
);

   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_LMR = 4'b0000;

   localparam int TW = (TRCD > 1) ? $clog2(TRCD) : 1;

   logic [3:0]        cmd;
   logic              is_act, is_rd, is_wr, is_pre, is_ref, is_lmr;
   logic [3:0]        bank_open;
   logic [12:0]       bank_row [4];
   logic [TW-1:0]     bank_tmr [4];
   logic              sel_open, sel_busy;
   logic [12:0]       sel_row;
   logic              mode_ok;
   logic [MEM_AW-1:0] idx;
   logic [15:0]       rd_word;
   logic [15:0]       mem [1<<MEM_AW];

   logic              do_act, do_rd, do_wr, do_ref, do_lmr;
   logic              err_now;
   logic [2:0]        code_now;
   logic              err_pend;
   logic [2:0]        code_pend;

   logic              rd1_v, rd1_cl3, rd2_v;
   logic [15:0]       rd1_d, rd2_d;

   // INHIBIT (cs=1) never matches any of the cs=0 encodings below.
   assign cmd    = {sd_cs, sd_ras, sd_cas, sd_we};
   assign is_act = (cmd == CMD_ACT);
   assign is_rd  = (cmd == CMD_RD);
   assign is_wr  = (cmd == CMD_WR);
   assign is_pre = (cmd == CMD_PRE);
   assign is_ref = (cmd == CMD_REF);
   assign is_lmr = (cmd == CMD_LMR);

   assign sel_open = bank_open[sd_ba];
   assign sel_row  = bank_row[sd_ba];
   assign sel_busy = (bank_tmr[sd_ba] != '0);

   assign mode_ok = (sd_addr[3:0] == 4'b0000) &&
                    ((sd_addr[6:4] == 3'd2) || (sd_addr[6:4] == 3'd3)) &&
                    (sd_addr[8:7] == 2'b00) && sd_addr[9];

   // Addresses wider than the store alias onto its low bits.
   assign idx     = MEM_AW'({sd_ba, sel_row, sd_addr[8:0]});
   assign rd_word = mem[idx];

   always_comb begin
      err_now  = 1'b0;
      code_now = 3'd0;
      do_act   = 1'b0;
      do_rd    = 1'b0;
      do_wr    = 1'b0;
      do_ref   = 1'b0;
      do_lmr   = 1'b0;
      if (is_act || is_rd || is_wr) begin
         if (!mode_set) begin
            err_now  = 1'b1;
            code_now = 3'd1;
         end else if (is_act) begin
            do_act = 1'b1;
            if (sel_open) begin
               err_now  = 1'b1;
               code_now = 3'd3;
            end
         end else if (!sel_open) begin
            err_now  = 1'b1;
            code_now = 3'd2;
         end else begin
            do_rd = is_rd;
            do_wr = is_wr;
            if (sel_busy) begin
               err_now  = 1'b1;
               code_now = 3'd4;
            end
         end
      end else if (is_ref) begin
         if (|bank_open) begin
            err_now  = 1'b1;
            code_now = 3'd5;
         end else begin
            do_ref = 1'b1;
         end
      end else if (is_lmr) begin
         if ((|bank_open) || !mode_ok) begin
            err_now  = 1'b1;
            code_now = 3'd6;
         end else begin
            do_lmr = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bank_open <= '0;
         for (int b = 0; b < 4; b++) begin
            bank_row[b] <= '0;
            bank_tmr[b] <= '0;
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (bank_tmr[b] != '0) bank_tmr[b] <= bank_tmr[b] - TW'(1);
         end
         if (do_act) begin
            bank_open[sd_ba] <= 1'b1;
            bank_row[sd_ba]  <= sd_addr;
            bank_tmr[sd_ba]  <= TW'(TRCD - 1);
         end
         if (is_pre) begin
            if (sd_addr[10]) bank_open <= '0;
            else             bank_open[sd_ba] <= 1'b0;
         end
         if ((do_rd || do_wr) && sd_addr[10]) bank_open[sd_ba] <= 1'b0;
      end
   end

   // Backing store is deliberately outside reset so contents survive it.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         if (!sd_dqm[1]) mem[idx][15:8] <= sd_data_in[15:8];
         if (!sd_dqm[0]) mem[idx][7:0]  <= sd_data_in[7:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_set    <= 1'b0;
         cas_lat     <= 2'd3;
         refresh_cnt <= '0;
         err_pend    <= 1'b0;
         code_pend   <= 3'd0;
         err         <= 1'b0;
         err_code    <= 3'd0;
      end else begin
         if (do_lmr) begin
            mode_set <= 1'b1;
            cas_lat  <= sd_addr[5:4];
         end
         if (do_ref) refresh_cnt <= refresh_cnt + 16'd1;
         err_pend  <= err_now;
         code_pend <= code_now;
         err       <= err_pend;
         if (err_pend) err_code <= code_pend;
      end
   end

   // Each read carries its own latency so a mode change never retimes it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd1_v       <= 1'b0;
         rd1_cl3     <= 1'b0;
         rd1_d       <= '0;
         rd2_v       <= 1'b0;
         rd2_d       <= '0;
         sd_data_oe  <= 1'b0;
         sd_data_out <= '0;
      end else begin
         rd1_v   <= do_rd;
         rd1_cl3 <= (cas_lat == 2'd3);
         rd1_d   <= rd_word;
         rd2_v   <= rd1_v && rd1_cl3;
         rd2_d   <= rd1_d;
         if (rd2_v) begin
            sd_data_oe  <= 1'b1;
            sd_data_out <= rd2_d;
         end else if (rd1_v && !rd1_cl3) begin
            sd_data_oe  <= 1'b1;
            sd_data_out <= rd1_d;
         end else begin
            sd_data_oe  <= 1'b0;
            sd_data_out <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: init, masked writes, CL2/CL3 reads,
// error codes and reset during an in-flight read.
module tb_sdram_responder;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_LMR = 4'b0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        sd_cs, sd_ras, sd_cas, sd_we;
   logic [12:0] sd_addr;
   logic [1:0]  sd_ba;
   logic [1:0]  sd_dqm;
   logic [15:0] sd_data_in;
   logic [15:0] sd_data_out;
   logic        sd_data_oe;
   logic        mode_set;
   logic [1:0]  cas_lat;
   logic [15:0] refresh_cnt;
   logic        err;
   logic [2:0]  err_code;

   int n_chk  = 0;
   int n_pass = 0;

   sdram_responder #(.MEM_AW(14), .TRCD(3)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sd_cs       (sd_cs),
      .sd_ras      (sd_ras),
      .sd_cas      (sd_cas),
      .sd_we       (sd_we),
      .sd_addr     (sd_addr),
      .sd_ba       (sd_ba),
      .sd_dqm      (sd_dqm),
      .sd_data_in  (sd_data_in),
      .sd_data_out (sd_data_out),
      .sd_data_oe  (sd_data_oe),
      .mode_set    (mode_set),
      .cas_lat     (cas_lat),
      .refresh_cnt (refresh_cnt),
      .err         (err),
      .err_code    (err_code)
   );

   always #5 clk = ~clk;

   // Drive one command, let the next rising edge sample it, return 1 ns later.
   task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                        input logic [1:0] dqm, input logic [15:0] d);
      {sd_cs, sd_ras, sd_cas, sd_we} = c;
      sd_ba      = ba;
      sd_addr    = a;
      sd_dqm     = dqm;
      sd_data_in = d;
      @(posedge clk);
      #1;
      {sd_cs, sd_ras, sd_cas, sd_we} = C_NOP;
      sd_dqm = 2'b00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      {sd_cs, sd_ras, sd_cas, sd_we} = C_NOP;
      sd_addr = '0; sd_ba = '0; sd_dqm = '0; sd_data_in = '0;
      idle(2);
      n_chk++; if (mode_set !== 1'b0) $display("FAIL rst_mode_set: got %0b want 0", mode_set); else n_pass++;
      n_chk++; if (cas_lat !== 2'd3) $display("FAIL rst_cas_lat: got %0d want 3", cas_lat); else n_pass++;
      n_chk++; if (refresh_cnt !== 16'd0) $display("FAIL rst_refresh_cnt: got %0d want 0", refresh_cnt); else n_pass++;
      n_chk++; if (sd_data_oe !== 1'b0) $display("FAIL rst_oe: got %0b want 0", sd_data_oe); else n_pass++;
      n_chk++; if (sd_data_out !== 16'h0) $display("FAIL rst_data: got %h want 0000", sd_data_out); else n_pass++;
      n_chk++; if (err !== 1'b0 || err_code !== 3'd0) $display("FAIL rst_err: got err=%0b code=%0d want 0/0", err, err_code); else n_pass++;
      reset_n = 1'b1;
      idle(1);
   endtask

   task automatic test_no_mode();
      issue(C_ACT, 2'd0, 13'h0001, 2'b00, 16'h0);
      n_chk++; if (err !== 1'b0) $display("FAIL nomode_err_early: got %0b want 0", err); else n_pass++;
      idle(1);
      n_chk++; if (err !== 1'b1 || err_code !== 3'd1) $display("FAIL nomode_err: got err=%0b code=%0d want 1/1", err, err_code); else n_pass++;
      idle(1);
      n_chk++; if (err !== 1'b0) $display("FAIL nomode_err_pulse: got %0b want 0", err); else n_pass++;
   endtask

   task automatic test_init();
      issue(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0);
      issue(C_LMR, 2'd0, 13'h0030, 2'b00, 16'h0);
      idle(1);
      n_chk++; if (err !== 1'b1 || err_code !== 3'd6 || mode_set !== 1'b0)
         $display("FAIL bad_mode: got err=%0b code=%0d mode_set=%0b want 1/6/0", err, err_code, mode_set); else n_pass++;
      issue(C_LMR, 2'd0, 13'h0230, 2'b00, 16'h0);
      n_chk++; if (mode_set !== 1'b1 || cas_lat !== 2'd3)
         $display("FAIL init_mode: got mode_set=%0b cl=%0d want 1/3", mode_set, cas_lat); else n_pass++;
      issue(C_ACT, 2'd1, 13'h0055, 2'b00, 16'h0);
      idle(1);
      n_chk++; if (err !== 1'b0) $display("FAIL init_err: got %0b want 0", err); else n_pass++;
      idle(1);
   endtask

   task automatic test_refresh();
      issue(C_ACT, 2'd0, 13'h0002, 2'b00, 16'h0);
      issue(C_ACT, 2'd0, 13'h0009, 2'b00, 16'h0);
      idle(1);
      n_chk++; if (err !== 1'b1 || err_code !== 3'd3) $display("FAIL act_open: got err=%0b code=%0d want 1/3", err, err_code); else n_pass++;
      issue(C_REF, 2'd0, 13'h0000, 2'b00, 16'h0);
      idle(1);
      n_chk++; if (err !== 1'b1 || err_code !== 3'd5 || refresh_cnt !== 16'd0)
         $display("FAIL ref_open: got err=%0b code=%0d cnt=%0d want 1/5/0", err, err_code, refresh_cnt); else n_pass++;
      issue(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0);
      issue(C_REF, 2'd0, 13'h0000, 2'b00, 16'h0);
      n_chk++; if (refresh_cnt !== 16'd1) $display("FAIL ref_ok: got cnt=%0d want 1", refresh_cnt); else n_pass++;
      idle(1);
      n_chk++; if (err !== 1'b0) $display("FAIL ref_ok_err: got %0b want 0", err); else n_pass++;
      issue(C_ACT, 2'd1, 13'h0055, 2'b00, 16'h0);
      idle(2);
   endtask

   task automatic test_write_read();
      issue(C_WR, 2'd1, 13'h0012, 2'b00, 16'h0000);
      issue(C_WR, 2'd1, 13'h0412, 2'b10, 16'hA5A5);
      issue(C_ACT, 2'd1, 13'h0055, 2'b00, 16'h0);
      idle(1);
      n_chk++; if (err !== 1'b0) $display("FAIL autopre_reopen: got err=%0b want 0", err); else n_pass++;
      idle(1);
      issue(C_RD, 2'd1, 13'h0012, 2'b00, 16'h0);
      n_chk++; if (sd_data_oe !== 1'b0) $display("FAIL cl3_oe_n0: got %0b want 0", sd_data_oe); else n_pass++;
      idle(1);
      n_chk++; if (sd_data_oe !== 1'b0) $display("FAIL cl3_oe_n1: got %0b want 0", sd_data_oe); else n_pass++;
      idle(1);
      n_chk++; if (sd_data_oe !== 1'b1 || sd_data_out !== 16'h00A5)
         $display("FAIL cl3_data: got oe=%0b data=%h want 1/00a5", sd_data_oe, sd_data_out); else n_pass++;
      idle(1);
      n_chk++; if (sd_data_oe !== 1'b0) $display("FAIL cl3_oe_n3: got %0b want 0", sd_data_oe); else n_pass++;
   endtask

   task automatic test_cl2_back_to_back();
      issue(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0);
      issue(C_LMR, 2'd0, 13'h0220, 2'b00, 16'h0);
      n_chk++; if (cas_lat !== 2'd2) $display("FAIL cl2_mode: got %0d want 2", cas_lat); else n_pass++;
      issue(C_ACT, 2'd2, 13'h0003, 2'b00, 16'h0);
      idle(2);
      issue(C_WR, 2'd2, 13'h0020, 2'b00, 16'h1111);
      issue(C_WR, 2'd2, 13'h0021, 2'b00, 16'h2222);
      issue(C_RD, 2'd2, 13'h0021, 2'b00, 16'h0);
      n_chk++; if (sd_data_oe !== 1'b0) $display("FAIL b2b_oe_n0: got %0b want 0", sd_data_oe); else n_pass++;
      issue(C_RD, 2'd2, 13'h0020, 2'b00, 16'h0);
      n_chk++; if (sd_data_oe !== 1'b1 || sd_data_out !== 16'h2222)
         $display("FAIL b2b_first: got oe=%0b data=%h want 1/2222", sd_data_oe, sd_data_out); else n_pass++;
      idle(1);
      n_chk++; if (sd_data_oe !== 1'b1 || sd_data_out !== 16'h1111)
         $display("FAIL b2b_second: got oe=%0b data=%h want 1/1111", sd_data_oe, sd_data_out); else n_pass++;
      idle(1);
      n_chk++; if (sd_data_oe !== 1'b0) $display("FAIL b2b_oe_end: got %0b want 0", sd_data_oe); else n_pass++;
   endtask

   task automatic test_trcd_errors();
      issue(C_ACT, 2'd3, 13'h0007, 2'b00, 16'h0);
      idle(1);
      issue(C_WR, 2'd3, 13'h0005, 2'b00, 16'hBEEF);
      idle(1);
      n_chk++; if (err !== 1'b1 || err_code !== 3'd4) $display("FAIL trcd_wr: got err=%0b code=%0d want 1/4", err, err_code); else n_pass++;
      issue(C_PRE, 2'd3, 13'h0000, 2'b00, 16'h0);
      issue(C_RD, 2'd3, 13'h0005, 2'b00, 16'h0);
      idle(1);
      n_chk++; if (err !== 1'b1 || err_code !== 3'd2 || sd_data_oe !== 1'b0)
         $display("FAIL rd_closed: got err=%0b code=%0d oe=%0b want 1/2/0", err, err_code, sd_data_oe); else n_pass++;
      issue(C_ACT, 2'd3, 13'h0007, 2'b00, 16'h0);
      idle(1);
      issue(C_RD, 2'd3, 13'h0005, 2'b00, 16'h0);
      idle(1);
      n_chk++; if (err !== 1'b1 || err_code !== 3'd4 || sd_data_oe !== 1'b1 || sd_data_out !== 16'hBEEF)
         $display("FAIL trcd_rd: got err=%0b code=%0d oe=%0b data=%h want 1/4/1/beef",
                  err, err_code, sd_data_oe, sd_data_out); else n_pass++;
      idle(1);
      n_chk++; if (err !== 1'b0 || sd_data_oe !== 1'b0) $display("FAIL trcd_end: got err=%0b oe=%0b want 0/0", err, sd_data_oe); else n_pass++;
      issue(C_RD, 2'd2, 13'h0020, 2'b00, 16'h0);
      idle(1);
      n_chk++; if (err !== 1'b0 || sd_data_oe !== 1'b1 || sd_data_out !== 16'h1111)
         $display("FAIL bank2_still_open: got err=%0b oe=%0b data=%h want 0/1/1111", err, sd_data_oe, sd_data_out); else n_pass++;
   endtask

   task automatic test_reset_midread();
      issue(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0);
      issue(C_LMR, 2'd0, 13'h0230, 2'b00, 16'h0);
      issue(C_ACT, 2'd1, 13'h0055, 2'b00, 16'h0);
      idle(2);
      issue(C_RD, 2'd1, 13'h0012, 2'b00, 16'h0);
      idle(1);
      reset_n = 1'b0;
      #1;
      n_chk++; if (sd_data_oe !== 1'b0 || mode_set !== 1'b0 || cas_lat !== 2'd3)
         $display("FAIL midrst_state: got oe=%0b mode_set=%0b cl=%0d want 0/0/3", sd_data_oe, mode_set, cas_lat); else n_pass++;
      n_chk++; if (refresh_cnt !== 16'd0 || err_code !== 3'd0)
         $display("FAIL midrst_cnt: got cnt=%0d code=%0d want 0/0", refresh_cnt, err_code); else n_pass++;
      #1;
      reset_n = 1'b1;
      idle(1);
      n_chk++; if (sd_data_oe !== 1'b0) $display("FAIL midrst_flush: got oe=%0b want 0", sd_data_oe); else n_pass++;
      idle(1);
      n_chk++; if (sd_data_oe !== 1'b0) $display("FAIL midrst_flush2: got oe=%0b want 0", sd_data_oe); else n_pass++;
      issue(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0);
      issue(C_LMR, 2'd0, 13'h0230, 2'b00, 16'h0);
      issue(C_ACT, 2'd1, 13'h0055, 2'b00, 16'h0);
      idle(2);
      issue(C_RD, 2'd1, 13'h0012, 2'b00, 16'h0);
      idle(2);
      n_chk++; if (sd_data_oe !== 1'b1 || sd_data_out !== 16'h00A5 || err !== 1'b0)
         $display("FAIL mem_kept: got oe=%0b data=%h err=%0b want 1/00a5/0", sd_data_oe, sd_data_out, err); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_no_mode();
      test_init();
      test_refresh();
      test_write_read();
      test_cl2_back_to_back();
      test_trcd_errors();
      test_reset_midread();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
